shift_add_mult32: RTL and testbench
===================================

// Module: shift_add_mult32
// PURPOSE
//  Iterative unsigned 32x32->64 multiplier built around a single adder32 instance,
//  one partial-product add per clock. Sits directly downstream of adder32: it is
//  the first sequential consumer of the adder's src1/src2/result datapath.
//  Valid/ready handshake on both sides, one operation in flight at a time.
// PARAMETERS
//  WIDTH  32  operand width; must equal adder32 width (only 32 is supported)
//  ITERS  32  add/shift steps per operation (= WIDTH)
//  CNT_W  6   step-counter width; must hold 0..ITERS
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   src1/src2 valid
//  in_ready   out  1   block can accept an operation
//  src1       in   32  multiplicand, unsigned
//  src2       in   32  multiplier, unsigned
//  out_valid  out  1   product valid
//  out_ready  in   1   consumer accepts product
//  product    out  64  src1*src2, unsigned, exact
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-op): state=IDLE, count=0, acc=0, mcand=0;
//    in_ready=1, out_valid=0, product=0. Any in-flight op is silently dropped.
//  - States: IDLE -> RUN on in_valid&in_ready; RUN -> DONE after step ITERS;
//    DONE -> IDLE on out_valid&out_ready. No other transitions.
//  - in_ready=1 only in IDLE; out_valid=1 only in DONE. Both registered-state decodes.
//  - Accept edge: mcand<=src1, acc_hi<=0, acc_lo<=src2, count<=0. src1/src2 ignored
//    in RUN and DONE.
//  - RUN step (one per edge): adder32.src1=acc_hi, adder32.src2 = acc_lo[0] ? mcand : 0;
//    c = (acc_hi[31]&a2[31]) | ((acc_hi[31]|a2[31]) & ~result[31]) (carry recovered,
//    adder32 has no carry-out); {acc_hi,acc_lo} <= {c,result,acc_lo} >> 1; count++.
//  - Latency: out_valid rises exactly ITERS (32) cycles after the accept edge.
//  - product = {acc_hi,acc_lo}; held stable while DONE & !out_ready (backpressure
//    unbounded). No early termination on zero operands: latency is data-independent.
//  - Result-accept edge and new-input accept never coincide (in_ready=0 in DONE);
//    earliest next accept is the cycle after the DONE->IDLE edge.
//  - All arithmetic mod 2^64 is exact; no overflow possible (32x32 fits in 64).
//  - adder32 is combinational; its path is the single-cycle critical path.
// STRUCTURE
//  - Shared package mult_pkg: WIDTH, ITERS, CNT_W constants; state encoding
//    (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 illegal -> IDLE).
//  - One sub-module: existing adder32 (src1, src2, result), instantiated once, unmodified.
//  - Top holds FSM, counter, mcand/acc_hi/acc_lo registers and carry-recovery logic.
// TESTING
//  - 0 x 0 -> product=64'h0, out_valid exactly 32 cycles after accept.
//  - 10 x 20 -> product=64'd200; in_ready low for all 32 RUN cycles + DONE.
//  - FFFFFFFF x FFFFFFFF -> 64'hFFFFFFFE_00000001 (exercises carry recovery every step).
//  - FFFFFFFF x 1 -> 64'h00000000_FFFFFFFF; 80000000 x 2 -> 64'h00000001_00000000.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> product/out_valid stable, then
//    handshake -> IDLE, in_ready=1 next cycle; back-to-back ops give correct results.
//  - rst pulsed at RUN step 10 -> immediately out_valid=0, in_ready=1, product=0;
//    next op 7 x 6 -> 64'd42. Plus 20 $random pairs vs {32'b0,a}*{32'b0,b}.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants, state encoding and carry-recovery helper for the
// shift-and-add multiplier built on adder32.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // adder32 drops the carry-out; it is rebuilt from the two operand MSBs and the sum MSB.
    function automatic logic recover_carry(input logic a_msb, input logic b_msb,
                                           input logic sum_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/adder32.sv
// Combinational 32-bit adder (modulo 2^32, no carry-out); the datapath
// that shift_add_mult32 reuses for every partial-product step.
module adder32 (
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    assign result = src1 + src2;

endmodule

// File: rtl/shift_add_mult32.sv
// Iterative unsigned 32x32->64 multiplier: one conditional add of the
// multiplicand into the upper accumulator half per clock, then a right shift.
module shift_add_mult32
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and a
    // pending product is held unchanged for as long as out_ready stays low.

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;

    assign add_b = acc_lo_q[0] ? mcand_q : '0;

    adder32 u_adder (
        .src1   (acc_hi_q),
        .src2   (add_b),
        .result (add_sum)
    );

    assign add_carry = recover_carry(acc_hi_q[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = src1;
                    acc_hi_d = '0;
                    acc_lo_d = src2;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // {carry, sum, acc_lo} shifted right by one: consumed multiplier bit falls off.
                acc_hi_d = {add_carry, add_sum[WIDTH-1:1]};
                acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_shift_add_mult32.sv
// Directed and random-operand bench for shift_add_mult32 with a queue-based
// product model and a per-cycle handshake/product compare.
module tb_shift_add_mult32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int total = 0;
    int bad   = 0;

    shift_add_mult32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an op occupies the block for 32 clocks, then its product waits for out_ready.
    logic [63:0] exp_q[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            exp_q.delete();
        end else if (!m_busy && !m_done) begin
            if (in_valid === 1'b1) begin
                m_busy <= 1'b1;
                m_left <= 32;
                exp_q.push_back({32'b0, src1} * {32'b0, src2});
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (out_ready === 1'b1) begin
            m_done <= 1'b0;
            void'(exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        check("in_ready", {63'b0, in_ready}, {63'b0, !m_busy && !m_done});
        check("out_valid", {63'b0, out_valid}, {63'b0, m_done});
        if (m_done && exp_q.size() > 0) begin
            check("model_product", product, exp_q[0]);
        end
    end

    // Starts between edges; returns #1 after the edge that completes the result handshake.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] lit, input int hold, input string name);
        int          lat;
        logic [63:0] p0;
        in_valid = 1'b1;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = $urandom;
        src2     = $urandom;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd32);
        if (!out_valid) return;
        check({name, "_product"}, product, lit);
        p0 = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, "_hold_valid"}, {63'b0, out_valid}, 64'd1);
            check({name, "_hold_product"}, product, p0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, "_ready_after"}, {63'b0, in_ready}, 64'd1);
        check({name, "_valid_after"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        src1      = '0;
        src2      = '0;
        #1;
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_product", product, 64'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(32'h0000_0000, 32'h0000_0000, 64'h0, 0, "zero");
        do_op(32'd10, 32'd20, 64'd200, 0, "ten_twenty");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "all_ones");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 0, "ones_x_one");
        do_op(32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0, "msb_x_two");
        do_op(32'h0000_DEAD, 32'h0001_0000, 64'h0000_0000_DEAD_0000, 5, "backpressure");
        do_op(32'd3, 32'd5, 64'd15, 0, "b2b_first");
        do_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0, "b2b_second");

        // Abort an operation after ten steps with an asynchronous reset.
        in_valid = 1'b1;
        src1     = 32'h1234_5678;
        src2     = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        check("midrst_product", product, 64'h0);
        rst = 1'b0;
        do_op(32'd7, 32'd6, 64'd42, 0, "after_reset");

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            do_op(a, b, {32'b0, a} * {32'b0, b}, i % 3, "random");
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
